// File: rtl/iterative_magnitude_comparator_if.sv
// ============================================================================
// iterative_magnitude_comparator_if
// Request/result bundle for the multi-cycle magnitude comparator.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface iterative_magnitude_comparator_if #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
);
  localparam int N    = WIDTH / SLICE;
  localparam int SU_W = $clog2(N) + 1;

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [SU_W-1:0]  slices_used;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, eq, gt, lt, slices_used
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, eq, gt, lt, slices_used
  );
endinterface

`default_nettype wire

// File: rtl/iterative_magnitude_comparator.sv
// ============================================================================
// iterative_magnitude_comparator
// Compares two WIDTH-bit operands one SLICE-bit slice per clock, MSB slice
// first, stopping at the first unequal slice. Unsigned or two's complement.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iterative_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  wire                              clk,
  input  wire                              rst,
  iterative_magnitude_comparator_if.slave  bus
);

  localparam int N     = WIDTH / SLICE;
  localparam int SU_W  = $clog2(N) + 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [WIDTH-1:0] c_MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [SU_W-1:0]  c_N        = SU_W'(N);
  localparam logic [IDX_W-1:0] c_IDX_TOP  = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;
  logic [SU_W-1:0]  r_slices_used;

  logic [WIDTH-1:0] w_flip;
  logic [SLICE-1:0] w_a_sl [N];
  logic [SLICE-1:0] w_b_sl [N];
  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;

  // Flipping the sign bit at latch time turns a two's-complement compare into
  // an unsigned one; only the MSB slice sees the change.
  assign w_flip = bus.signed_mode ? c_MSB_MASK : '0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign w_a_sl[gi] = r_a[gi*SLICE +: SLICE];
      assign w_b_sl[gi] = r_b[gi*SLICE +: SLICE];
    end
  endgenerate

  assign w_sa = w_a_sl[r_idx];
  assign w_sb = w_b_sl[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_eq          <= 1'b0;
      r_gt          <= 1'b0;
      r_lt          <= 1'b0;
      r_slices_used <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_a     <= bus.a ^ w_flip;
            r_b     <= bus.b ^ w_flip;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_idx   <= c_IDX_TOP;
            r_state <= S_BUSY;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (w_sa != w_sb) begin
            r_gt          <= (w_sa > w_sb);
            r_lt          <= (w_sa < w_sb);
            r_slices_used <= c_N - SU_W'(r_idx);
            r_state       <= S_DONE;
          end else if (r_idx == '0) begin
            r_eq          <= 1'b1;
            r_slices_used <= c_N;
            r_state       <= S_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state == S_BUSY);
  assign bus.done        = (r_state == S_DONE);
  assign bus.eq          = r_eq;
  assign bus.gt          = r_gt;
  assign bus.lt          = r_lt;
  assign bus.slices_used = r_slices_used;

endmodule

`default_nettype wire

// File: tb/tb_iterative_magnitude_comparator.sv
// ============================================================================
// tb_iterative_magnitude_comparator
// Directed vector table plus hand-written reset / busy / back-to-back sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iterative_magnitude_comparator;

  localparam int WIDTH = 8;
  localparam int SLICE = 2;
  localparam int BOUND = 20;

  logic clk;
  logic rst;

  iterative_magnitude_comparator_if #(.WIDTH(WIDTH), .SLICE(SLICE)) bus ();

  iterative_magnitude_comparator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic       eq;
    logic       gt;
    logic       lt;
    int         su;
  } vec_t;

  vec_t vecs [12];
  int   n_vec;
  int   n_err;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive start for one edge; returns #1 after the acceptance edge.
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic sm);
    bus.start       = 1'b1;
    bus.a           = a;
    bus.b           = b;
    bus.signed_mode = sm;
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < BOUND) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= BOUND) chk("done_timeout", cyc, -1);
  endtask

  task automatic chk_result(input string tag, input vec_t v, input int cyc);
    chk({tag, "_latency"}, cyc, v.su);
    chk({tag, "_eq"}, int'(bus.eq), int'(v.eq));
    chk({tag, "_gt"}, int'(bus.gt), int'(v.gt));
    chk({tag, "_lt"}, int'(bus.lt), int'(v.lt));
    chk({tag, "_su"}, int'(bus.slices_used), v.su);
  endtask

  initial begin
    int   cyc;
    vec_t v;
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{8'hA5, 8'h25, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    vecs[2]  = '{8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 4};
    vecs[3]  = '{8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[4]  = '{8'h80, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[5]  = '{8'h34, 8'h35, 1'b0, 1'b0, 1'b0, 1'b1, 4};
    vecs[6]  = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    vecs[7]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[8]  = '{8'h12, 8'h1A, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    vecs[9]  = '{8'hC0, 8'hC4, 1'b1, 1'b0, 1'b0, 1'b1, 3};
    vecs[10] = '{8'h7F, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[11] = '{8'h20, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 2};

    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_eq",   int'(bus.eq), 0);
    chk("rst_gt",   int'(bus.gt), 0);
    chk("rst_lt",   int'(bus.lt), 0);
    chk("rst_su",   int'(bus.slices_used), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].sm);
      chk($sformatf("v%0d_busy", i), int'(bus.busy), 1);
      chk($sformatf("v%0d_clear", i), int'({bus.eq, bus.gt, bus.lt}), 0);
      // Operands wiggling after acceptance must not matter.
      bus.a = ~vecs[i].a;
      bus.b = ~vecs[i].b;
      bus.signed_mode = ~vecs[i].sm;
      wait_done(cyc);
      chk_result($sformatf("v%0d", i), vecs[i], cyc);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse", i), int'(bus.done), 0);
      chk($sformatf("v%0d_held", i), int'({bus.eq, bus.gt, bus.lt}),
          int'({vecs[i].eq, vecs[i].gt, vecs[i].lt}));
    end

    // start while busy is ignored
    accept(8'h00, 8'hFF, 1'b0);
    bus.start = 1'b1;
    bus.a     = 8'h11;
    bus.b     = 8'h11;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    v = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    chk_result("ign", v, 1);
    chk("ign_done", int'(bus.done), 1);
    @(posedge clk);
    #1;
    chk("ign_idle", int'(bus.busy), 0);

    // asynchronous reset mid-compare
    accept(8'h3C, 8'h3C, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_flags", int'({bus.eq, bus.gt, bus.lt}), 0);
    chk("arst_su", int'(bus.slices_used), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    accept(vecs[8].a, vecs[8].b, vecs[8].sm);
    wait_done(cyc);
    chk_result("post_rst", vecs[8], cyc);
    @(posedge clk);
    #1;

    // back-to-back: start during the done cycle
    accept(vecs[11].a, vecs[11].b, vecs[11].sm);
    wait_done(cyc);
    chk_result("b2b_first", vecs[11], cyc);
    accept(vecs[5].a, vecs[5].b, vecs[5].sm);
    chk("b2b_busy", int'(bus.busy), 1);
    chk("b2b_done", int'(bus.done), 0);
    chk("b2b_clear", int'({bus.eq, bus.gt, bus.lt}), 0);
    wait_done(cyc);
    chk_result("b2b_second", vecs[5], cyc);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
